// File: rtl/load_store_unit.sv
// Byte-addressed RISC-V load/store front end for a word-organised data memory.
// Sub-word stores are done as read-modify-write; loads are lane-selected and extended.
module load_store_unit #(
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [2:0]        req_funct3,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_fault,
    output logic              MemRead,
    output logic              MemWrite,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RMW_RD,
        RMW_WR,
        WRITE,
        FAULT,
        RESP
    } state_t;

    state_t              state;
    logic [2:0]          cap_funct3;
    logic [ADDR_W+1:0]   cap_addr;
    logic [31:0]         cap_wdata;
    logic [31:0]         old_word;
    logic [31:0]         load_data;
    logic [31:0]         merged_word;
    logic [7:0]          byte_sel;
    logic [15:0]         half_sel;
    logic                unused_addr_hi;

    assign unused_addr_hi = ^req_addr[31:ADDR_W+2];

    function automatic logic is_fault(input logic write, input logic [2:0] f3,
                                      input logic [1:0] off);
        logic bad_f3;
        logic misaligned;
        bad_f3     = write ? !(f3 inside {3'b000, 3'b001, 3'b010})
                           : (f3 inside {3'b011, 3'b110, 3'b111});
        misaligned = ((f3[1:0] == 2'b01) && off[0]) ||
                     ((f3[1:0] == 2'b10) && (off != 2'b00));
        return bad_f3 || misaligned;
    endfunction

    always_comb begin
        byte_sel  = mem_rdata[{cap_addr[1:0], 3'b000} +: 8];
        half_sel  = cap_addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        load_data = mem_rdata;
        case (cap_funct3)
            3'b000:  load_data = {{24{byte_sel[7]}}, byte_sel};
            3'b001:  load_data = {{16{half_sel[15]}}, half_sel};
            3'b100:  load_data = {24'd0, byte_sel};
            3'b101:  load_data = {16'd0, half_sel};
            default: load_data = mem_rdata;
        endcase
    end

    // funct3[0] distinguishes SH from SB; only those two reach the RMW path
    always_comb begin
        merged_word = old_word;
        if (cap_funct3[0])
            merged_word[{cap_addr[1], 4'b0000} +: 16] = cap_wdata[15:0];
        else
            merged_word[{cap_addr[1:0], 3'b000} +: 8] = cap_wdata[7:0];
    end

    assign req_ready  = (state == IDLE);
    assign resp_valid = (state == RESP);
    assign MemRead    = (state == LOAD) || (state == RMW_RD);
    assign MemWrite   = (state == RMW_WR) || (state == WRITE);
    assign mem_addr   = cap_addr[ADDR_W+1:2];
    assign mem_wdata  = (state == RMW_WR) ? merged_word :
                        (state == WRITE)  ? cap_wdata   : 32'd0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            cap_funct3 <= 3'd0;
            cap_addr   <= '0;
            cap_wdata  <= 32'd0;
            old_word   <= 32'd0;
            resp_rdata <= 32'd0;
            resp_fault <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        cap_funct3 <= req_funct3;
                        cap_addr   <= req_addr[ADDR_W+1:0];
                        cap_wdata  <= req_wdata;
                        resp_rdata <= 32'd0;
                        if (is_fault(req_write, req_funct3, req_addr[1:0]))
                            state <= FAULT;
                        else if (!req_write)
                            state <= LOAD;
                        else if (req_funct3 == 3'b010)
                            state <= WRITE;
                        else
                            state <= RMW_RD;
                    end
                end
                LOAD: begin
                    resp_rdata <= load_data;
                    state      <= RESP;
                end
                RMW_RD: begin
                    old_word <= mem_rdata;
                    state    <= RMW_WR;
                end
                RMW_WR:  state <= RESP;
                WRITE:   state <= RESP;
                FAULT: begin
                    resp_fault <= 1'b1;
                    resp_rdata <= 32'd0;
                    state      <= RESP;
                end
                RESP: begin
                    resp_fault <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
